// File: rtl/pipe_hazard_ctrl.sv
// Issue/stall/flush sequencer for a 3-stage pipeline with a 32-entry RAW/WAW scoreboard.
// Optional performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_IDX_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic                 dec_use_rs1,
  input  logic                 dec_use_rs2,
  input  logic [REG_IDX_W-1:0] dec_rd,
  input  logic                 dec_wr_en,
  input  logic                 cntl_transfer,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  output logic                 issue,
  output logic                 stall,
  output logic                 flush,
  output logic [1:0]           state,
  output logic [31:0]          pending
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [15:0]          perf_stall_cnt,
  output logic [15:0]          perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pending_q, pending_d;

  logic raw1, raw2, waw, hazard, flushing;
  logic issue_raw, stall_raw;

  // Register 0 is hardwired, so it can never be a hazard source.
  always_comb begin
    raw1      = dec_use_rs1 & (dec_rs1 != '0) & pending_q[dec_rs1];
    raw2      = dec_use_rs2 & (dec_rs2 != '0) & pending_q[dec_rs2];
    waw       = dec_wr_en   & (dec_rd  != '0) & pending_q[dec_rd];
    hazard    = raw1 | raw2 | waw;
    flushing  = (state_q == ST_FLUSH) | cntl_transfer;
    issue_raw = dec_valid & ~hazard & ~flushing;
    stall_raw = dec_valid &  hazard & ~flushing;
  end

  // Handshake outputs are forced low for as long as reset is asserted.
  assign issue   = rst & issue_raw;
  assign stall   = rst & stall_raw;
  assign flush   = rst & flushing;
  assign state   = state_q;
  assign pending = pending_q;

  always_comb begin
    pending_d = pending_q;
    if (wb_valid) pending_d[wb_rd] = 1'b0;
    if (issue_raw && dec_wr_en && (dec_rd != '0)) pending_d[dec_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN:   if (stall_raw) state_d = ST_STALL;
      ST_STALL: if (!hazard || !dec_valid) state_d = ST_RUN;
      ST_FLUSH: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      default:  state_d = ST_RUN;
    endcase
    // A transfer always (re)starts the flush window, even mid-flush.
    if (cntl_transfer) begin
      state_d = ST_FLUSH;
      cnt_d   = FLUSH_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_raw && (perf_stall_q != 16'hFFFF)) perf_stall_d = perf_stall_q + 16'd1;
    if (cntl_transfer && (state_q != ST_FLUSH) && (perf_flush_q != 16'hFFFF))
      perf_flush_d = perf_flush_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a randomized run
// against a behavioural model (scoreboard array, flush countdown, stall flag).
module tb_pipe_hazard_ctrl;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_use_rs1, dec_use_rs2, dec_wr_en;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        cntl_transfer, wb_valid;
  logic        issue, stall, flush;
  logic [1:0]  state;
  logic [31:0] pending;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_IDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_wr_en(dec_wr_en),
    .cntl_transfer(cntl_transfer), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue(issue), .stall(stall), .flush(flush), .state(state), .pending(pending)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit          pend [32];
  int          flush_left;
  bit          stalled;
  int          m_pstall, m_pflush;
  logic        m_haz, exp_issue, exp_stall, exp_flush;
  logic [1:0]  exp_state;
  logic [31:0] exp_pending;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    flush_left = 0;
    stalled    = 1'b0;
    m_pstall   = 0;
    m_pflush   = 0;
  endtask

  task automatic model_eval();
    logic fl;
    m_haz = (dec_use_rs1 && dec_rs1 != 0 && pend[dec_rs1]) ||
            (dec_use_rs2 && dec_rs2 != 0 && pend[dec_rs2]) ||
            (dec_wr_en   && dec_rd  != 0 && pend[dec_rd]);
    fl        = (flush_left > 0) || cntl_transfer;
    exp_issue = rst && dec_valid && !m_haz && !fl;
    exp_stall = rst && dec_valid &&  m_haz && !fl;
    exp_flush = rst && fl;
    exp_state = (flush_left > 0) ? 2'd2 : (stalled ? 2'd1 : 2'd0);
    for (int i = 0; i < 32; i++) exp_pending[i] = pend[i];
  endtask

  // Advance one clock edge and update the model from the pre-edge inputs.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      if (exp_stall && m_pstall < 65535) m_pstall++;
      if (cntl_transfer && flush_left == 0 && m_pflush < 65535) m_pflush++;
      if (wb_valid) pend[wb_rd] = 1'b0;
      if (exp_issue && dec_wr_en && dec_rd != 0) pend[dec_rd] = 1'b1;
      stalled = !cntl_transfer && flush_left == 0 && dec_valid && m_haz;
      if (cntl_transfer) flush_left = FC;
      else if (flush_left > 0) flush_left--;
    end
    #1;
  endtask

  task automatic set_dec(input logic dv, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wr);
    dec_valid = dv; dec_rs1 = rs1; dec_use_rs1 = u1;
    dec_rs2 = rs2; dec_use_rs2 = u2; dec_rd = rd; dec_wr_en = wr;
  endtask

  task automatic set_ctl(input logic ct, input logic wbv, input logic [4:0] wbr);
    cntl_transfer = ct; wb_valid = wbv; wb_rd = wbr;
  endtask

  task automatic idle();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    set_ctl(0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_dec(1, 3, 1, 4, 1, 6, 1);
    set_ctl(1, 1, 6);
    @(negedge clk);
    model_reset();
    n_checks++;
    if ({issue, stall, flush} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got %b expected 000", {issue, stall, flush});
    end
    n_checks++;
    if (state !== 2'b00) begin
      n_fail++; $display("[TB] FAIL reset_state: got %b expected 00", state);
    end
    n_checks++;
    if (pending !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_pending: got %h expected 0", pending);
    end
    idle();
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (state !== 2'b00 || {issue, stall, flush} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_release: got state %b outs %b expected 00/000", state, {issue, stall, flush});
    end
    tick();
  endtask

  task automatic test_raw_stall();
    logic [2:0] exp_o [4] = '{3'b100, 3'b010, 3'b010, 3'b100};
    logic [1:0] exp_s [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin set_dec(1, 0, 0, 0, 0, 5, 1); set_ctl(0, 0, 0); end
        1: begin set_dec(1, 5, 1, 0, 0, 0, 0); set_ctl(0, 0, 0); end
        2: begin set_dec(1, 5, 1, 0, 0, 0, 0); set_ctl(0, 1, 5); end
        default: begin set_dec(1, 5, 1, 0, 0, 0, 0); set_ctl(0, 0, 0); end
      endcase
      @(negedge clk);
      n_checks++;
      if ({issue, stall, flush} !== exp_o[c] || state !== exp_s[c]) begin
        n_fail++;
        $display("[TB] FAIL raw_cycle%0d: got outs %b state %b expected %b/%b",
                 c, {issue, stall, flush}, state, exp_o[c], exp_s[c]);
      end
      tick();
    end
    idle();
    @(negedge clk);
    n_checks++;
    if (pending[5] !== 1'b0 || state !== 2'b00) begin
      n_fail++; $display("[TB] FAIL raw_release: got pending5 %b state %b expected 0/00", pending[5], state);
    end
    tick();
  endtask

  task automatic test_x0();
    set_dec(1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    n_checks++;
    if ({issue, stall} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL x0_write_issue: got %b expected 10", {issue, stall});
    end
    tick();
    set_dec(1, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    n_checks++;
    if (pending !== 32'h0 || {issue, stall} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL x0_read: got pending %h outs %b expected 0/10", pending, {issue, stall});
    end
    tick();
    idle();
  endtask

  task automatic test_flush();
    bit         ct_seq [10] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    logic       fl_seq [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    logic [1:0] st_seq [10] = '{0, 2, 2, 0, 0, 2, 2, 2, 2, 0};
    for (int c = 0; c < 10; c++) begin
      set_dec(1, 0, 0, 0, 0, 0, 0);
      set_ctl(ct_seq[c], 0, 0);
      @(negedge clk);
      n_checks++;
      if (flush !== fl_seq[c] || issue !== !fl_seq[c] || stall !== 1'b0 || state !== st_seq[c]) begin
        n_fail++;
        $display("[TB] FAIL flush_cycle%0d: got flush %b issue %b stall %b state %b expected %b/%b/0/%b",
                 c, flush, issue, stall, state, fl_seq[c], !fl_seq[c], st_seq[c]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_collision();
    set_dec(1, 0, 0, 0, 0, 7, 1);
    set_ctl(0, 1, 7);
    @(negedge clk);
    n_checks++;
    if (issue !== 1'b1 || pending[7] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL collide_pre: got issue %b pending7 %b expected 1/0", issue, pending[7]);
    end
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (pending !== 32'h0000_0080) begin
      n_fail++; $display("[TB] FAIL collide_set_wins: got %h expected 00000080", pending);
    end
    set_ctl(0, 1, 7);
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (pending !== 32'h0) begin
      n_fail++; $display("[TB] FAIL collide_clear: got %h expected 0", pending);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      set_dec(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), 1'($urandom),
              5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
      set_ctl(($urandom_range(0, 11) == 0), ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)));
      @(negedge clk);
      model_eval();
      n_checks++;
      if ({issue, stall, flush, state} !== {exp_issue, exp_stall, exp_flush, exp_state} ||
          pending !== exp_pending) begin
        n_fail++;
        $display("[TB] FAIL random_cycle%0d: got outs %b state %b pending %h expected %b/%b/%h",
                 c, {issue, stall, flush}, state, pending,
                 {exp_issue, exp_stall, exp_flush}, exp_state, exp_pending);
      end
      tick();
    end
    idle();
    for (int r = 0; r < 32; r++) begin
      set_ctl(0, 1, 5'(r));
      tick();
    end
    idle();
  endtask

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  task automatic test_perf();
    rst = 1'b0;
    idle();
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    tick();
    for (int t = 0; t < 3; t++) begin
      set_ctl(1, 0, 0);
      tick();
      set_ctl(0, 0, 0);
      for (int k = 0; k < 4; k++) tick();
    end
    @(negedge clk);
    n_checks++;
    if (perf_flush_cnt !== 16'd3 || perf_flush_cnt !== 16'(m_pflush)) begin
      n_fail++; $display("[TB] FAIL perf_flush: got %0d expected 3", perf_flush_cnt);
    end
    set_dec(1, 0, 0, 0, 0, 9, 1);
    tick();
    set_dec(1, 9, 1, 0, 0, 0, 0);
    for (int k = 0; k < 70000; k++) tick();
    @(negedge clk);
    n_checks++;
    if (perf_stall_cnt !== 16'hFFFF || m_pstall != 65535) begin
      n_fail++; $display("[TB] FAIL perf_stall_sat: got %h expected FFFF", perf_stall_cnt);
    end
    idle();
    set_ctl(0, 1, 9);
    tick();
    idle();
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    test_reset();
    test_raw_stall();
    test_x0();
    test_flush();
    test_collision();
    test_random();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
